fixed_p_mult_arbiter: RTL and testbench

Shares one pipelined unsigned fixed-point multiplier among `NUM_REQ` go/done requesters, using round-robin arbitration. It sits between the Calyx-generated control of several groups and a single multiply datapath, so that a design instantiates one multiplier instead of one per group. Each requester sees a private go/done multiply port whose result is held stable until that requester's next `done`.

---
 rtl/fixed_p_pkg.sv | 23 ++
 rtl/fixed_p_rr_arbiter.sv | 30 +++
 rtl/fixed_p_mult_arbiter.sv | 170 +++++++++++++++++
 tb/tb_fixed_p_mult_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_p_pkg.sv
// Shared constants and product-slicing helpers for the fixed-point multiplier arbiter.
// fixed_p_sat is only referenced when FIXED_P_MULT_ARB_SAT_EN is defined.
package fixed_p_pkg;

  localparam int MAX_NUM_REQ = 8;
  localparam int MAX_LATENCY = 8;
  localparam int MAX_WIDTH   = 64;

  // Widest full product the helpers accept; callers zero-extend into it.
  typedef logic [2*MAX_WIDTH-1:0] prod_t;

  // Drops the fraction bits; the caller keeps the low WIDTH bits (wrap on overflow).
  function automatic prod_t fixed_p_trunc(input prod_t product, input int fract_width);
    return product >> fract_width;
  endfunction

  // True when any bit above the representable integer range is set.
  function automatic logic fixed_p_sat(input prod_t product, input int width,
                                       input int fract_width);
    return |(product >> (width + fract_width));
  endfunction

endpackage

// File: rtl/fixed_p_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr wins, with wrap-around.
module fixed_p_rr_arbiter #(
  parameter  int N     = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int k;
    // NOTE: every output gets a default before the search so no latch is inferred.
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    k     = 0;
    for (int off = 0; off < N; off++) begin
      k = (int'(ptr) + off) % N;
      if (!any && req[k]) begin
        any      = 1'b1;
        grant[k] = 1'b1;
        idx      = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/fixed_p_mult_arbiter.sv
// One pipelined unsigned fixed-point multiplier shared round-robin by NUM_REQ go/done ports.
// Define FIXED_P_MULT_ARB_SAT_EN for saturation plus a per-requester overflow pulse.
module fixed_p_mult_arbiter
  import fixed_p_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int INT_WIDTH   = 8,
  parameter int FRACT_WIDTH = 24,
  parameter int NUM_REQ     = 4,
  parameter int LATENCY     = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       go,
  input  logic [NUM_REQ*WIDTH-1:0] left,
  input  logic [NUM_REQ*WIDTH-1:0] right,
  output logic [NUM_REQ*WIDTH-1:0] out,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy
`ifdef FIXED_P_MULT_ARB_SAT_EN
  ,
  output logic [NUM_REQ-1:0]       overflow
`endif
);

  localparam int TAG_W = $clog2(NUM_REQ);

  if (INT_WIDTH + FRACT_WIDTH != WIDTH) begin : g_bad_width
    $error("fixed_p_mult_arbiter: INT_WIDTH + FRACT_WIDTH must equal WIDTH");
  end
  if (NUM_REQ < 2 || NUM_REQ > MAX_NUM_REQ) begin : g_bad_num_req
    $error("fixed_p_mult_arbiter: NUM_REQ out of range");
  end
  if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("fixed_p_mult_arbiter: LATENCY out of range");
  end
  if (WIDTH > MAX_WIDTH) begin : g_bad_max_width
    $error("fixed_p_mult_arbiter: WIDTH exceeds MAX_WIDTH");
  end

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] result;
`ifdef FIXED_P_MULT_ARB_SAT_EN
    logic             ovf;
`endif
  } payload_t;

  logic [TAG_W-1:0]         ptr_q;
  logic [NUM_REQ-1:0]       pending_q;
  logic [NUM_REQ-1:0]       done_q;
  logic [NUM_REQ*WIDTH-1:0] out_q;
  logic                     busy_q;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [TAG_W-1:0]   grant_idx;
  logic               entry_valid;
  logic [TAG_W-1:0]   next_ptr;

  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [2*WIDTH-1:0] product;
  payload_t           entry_data;

  logic               exit_valid;
  payload_t           exit_data;
  logic               pipe_busy;
  logic [NUM_REQ-1:0] clear;

  // A requester in its done cycle is held off so it sees the result before re-arming.
  assign eligible = go & ~pending_q & ~done_q;

  fixed_p_rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req   (eligible),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (grant_idx),
    .any   (entry_valid)
  );

  assign next_ptr = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + TAG_W'(1);

  // The multiply sits in front of the first pipeline register; later stages only retime.
  always_comb begin
    op_a       = left[int'(grant_idx)*WIDTH +: WIDTH];
    op_b       = right[int'(grant_idx)*WIDTH +: WIDTH];
    product    = (2*WIDTH)'(op_a) * (2*WIDTH)'(op_b);
    entry_data = '0;
    entry_data.tag = grant_idx;
`ifdef FIXED_P_MULT_ARB_SAT_EN
    entry_data.ovf    = fixed_p_sat(prod_t'(product), WIDTH, FRACT_WIDTH);
    entry_data.result = entry_data.ovf ? '1
                                       : WIDTH'(fixed_p_trunc(prod_t'(product), FRACT_WIDTH));
`else
    entry_data.result = WIDTH'(fixed_p_trunc(prod_t'(product), FRACT_WIDTH));
`endif
  end

  // LATENCY-1 retiming stages; the output registers below form the final stage.
  if (LATENCY == 1) begin : g_direct
    assign exit_valid = entry_valid;
    assign exit_data  = entry_data;
    assign pipe_busy  = 1'b0;
  end else begin : g_pipe
    logic [LATENCY-2:0] valid_q;
    payload_t           data_q [LATENCY-1];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        valid_q <= '0;
      end else begin
        valid_q[0] <= entry_valid;
        for (int k = 1; k < LATENCY - 1; k++) valid_q[k] <= valid_q[k-1];
      end
    end

    // NOTE: payload registers carry no reset; the valid bits alone decide whether they mean anything.
    always_ff @(posedge clk) begin
      data_q[0] <= entry_data;
      for (int k = 1; k < LATENCY - 1; k++) data_q[k] <= data_q[k-1];
    end

    assign exit_valid = valid_q[LATENCY-2];
    assign exit_data  = data_q[LATENCY-2];
    assign pipe_busy  = |valid_q;
  end

  always_comb begin
    clear = '0;
    if (exit_valid) clear[exit_data.tag] = 1'b1;
  end

  // NOTE: all state below updates with non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q     <= '0;
      pending_q <= '0;
      done_q    <= '0;
      out_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      busy_q    <= entry_valid | pipe_busy;
      pending_q <= (pending_q | grant) & ~clear;
      done_q    <= clear;
      if (entry_valid) ptr_q <= next_ptr;
      if (exit_valid) out_q[int'(exit_data.tag)*WIDTH +: WIDTH] <= exit_data.result;
    end
  end

`ifdef FIXED_P_MULT_ARB_SAT_EN
  logic [NUM_REQ-1:0] ovf_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= '0;
      if (exit_valid && exit_data.ovf) ovf_q[exit_data.tag] <= 1'b1;
    end
  end

  assign overflow = ovf_q;
`endif

  assign out  = out_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_fixed_p_mult_arbiter.sv
// Directed bench for fixed_p_mult_arbiter (defaults, LATENCY=3); follows FIXED_P_MULT_ARB_SAT_EN.
module tb_fixed_p_mult_arbiter;

  localparam int WIDTH   = 32;
  localparam int NUM_REQ = 4;
  localparam int LATENCY = 3;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic [NUM_REQ-1:0]       go;
  logic [NUM_REQ*WIDTH-1:0] left;
  logic [NUM_REQ*WIDTH-1:0] right;
  logic [NUM_REQ*WIDTH-1:0] out;
  logic [NUM_REQ-1:0]       done;
  logic                     busy;
`ifdef FIXED_P_MULT_ARB_SAT_EN
  logic [NUM_REQ-1:0]       overflow;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fixed_p_mult_arbiter #(
    .WIDTH       (WIDTH),
    .INT_WIDTH   (8),
    .FRACT_WIDTH (24),
    .NUM_REQ     (NUM_REQ),
    .LATENCY     (LATENCY)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .go       (go),
    .left     (left),
    .right    (right),
    .out      (out),
    .done     (done),
    .busy     (busy)
`ifdef FIXED_P_MULT_ARB_SAT_EN
    ,
    .overflow (overflow)
`endif
  );

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    go = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_ops(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    left[i*WIDTH +: WIDTH]  = a;
    right[i*WIDTH +: WIDTH] = b;
  endtask

  function automatic logic [WIDTH-1:0] slice(input logic [NUM_REQ*WIDTH-1:0] v, input int i);
    return v[i*WIDTH +: WIDTH];
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    go      = '0;
    left    = '0;
    right   = '0;
    step();
    step();
    total++;
    if (done !== '0) begin bad++; $display("FAIL reset_done got=%b want=0000", done); end
    total++;
    if (out !== '0) begin bad++; $display("FAIL reset_out got=%h want=0", out); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    set_ops(0, 32'h0180_0000, 32'h0200_0000);
    go = 4'b0001;
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 1) begin
        go = '0;
        set_ops(0, 32'hDEAD_BEEF, 32'h1234_5678);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_t1 got=%b want=1", busy); end
      end
      total++;
      if (done !== ((c == 3) ? 4'b0001 : 4'b0000)) begin
        bad++; $display("FAIL single_done c=%0d got=%b", c, done);
      end
      if (c >= 3) begin
        total++;
        if (slice(out, 0) !== 32'h0300_0000) begin
          bad++; $display("FAIL single_out c=%0d got=%h want=03000000", c, slice(out, 0));
        end
      end
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_idle got=%b want=0", busy); end
    idle(2);
  endtask

  task automatic test_contention();
    logic [WIDTH-1:0] exp_out [NUM_REQ];
    logic [NUM_REQ-1:0] exp_done;
    exp_out[0] = 32'h0100_0000;
    exp_out[1] = 32'h0600_0000;
    exp_out[2] = 32'h0040_0000;
    exp_out[3] = 32'h0000_0001;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    set_ops(0, 32'h0100_0000, 32'h0100_0000);
    set_ops(1, 32'h0200_0000, 32'h0300_0000);
    set_ops(2, 32'h0080_0000, 32'h0080_0000);
    set_ops(3, 32'h0000_0003, 32'h0080_0000);
    go = 4'b1111;
    for (int c = 1; c <= 7; c++) begin
      step();
      if (c <= NUM_REQ) go[c-1] = 1'b0;
      exp_done = (c >= 3 && c <= 6) ? 4'(1 << (c - 3)) : 4'b0000;
      total++;
      if (done !== exp_done) begin
        bad++; $display("FAIL contention_done c=%0d got=%b want=%b", c, done, exp_done);
      end
      if (c >= 3 && c <= 6) begin
        total++;
        if (slice(out, c - 3) !== exp_out[c-3]) begin
          bad++;
          $display("FAIL contention_out req=%0d got=%h want=%h", c - 3, slice(out, c - 3), exp_out[c-3]);
        end
      end
    end
    idle(2);
  endtask

  task automatic test_rotation();
    logic [NUM_REQ-1:0] exp_done;
    set_ops(1, 32'h0100_0000, 32'h0040_0000);
    set_ops(2, 32'h0180_0000, 32'h0180_0000);
    set_ops(3, 32'h0020_0000, 32'h0400_0000);
    go = 4'b0100;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) go = 4'b1010;
      if (c == 2) go[3] = 1'b0;
      if (c == 3) go[1] = 1'b0;
      case (c)
        3:       exp_done = 4'b0100;
        4:       exp_done = 4'b1000;
        5:       exp_done = 4'b0010;
        default: exp_done = 4'b0000;
      endcase
      total++;
      if (done !== exp_done) begin
        bad++; $display("FAIL rotation_done c=%0d got=%b want=%b", c, done, exp_done);
      end
    end
    total++;
    if (slice(out, 2) !== 32'h0240_0000) begin
      bad++; $display("FAIL rotation_out2 got=%h want=02400000", slice(out, 2));
    end
    total++;
    if (slice(out, 3) !== 32'h0080_0000) begin
      bad++; $display("FAIL rotation_out3 got=%h want=00800000", slice(out, 3));
    end
    total++;
    if (slice(out, 1) !== 32'h0040_0000) begin
      bad++; $display("FAIL rotation_out1 got=%h want=00400000", slice(out, 1));
    end
    idle(2);
  endtask

  task automatic test_overflow();
    logic [WIDTH-1:0] exp_val;
`ifdef FIXED_P_MULT_ARB_SAT_EN
    exp_val = 32'hFFFF_FFFF;
`else
    exp_val = 32'h0000_0000;
`endif
    set_ops(2, 32'h1000_0000, 32'h1000_0000);
    go = 4'b0100;
    for (int c = 1; c <= 3; c++) begin
      step();
      if (c == 1) go = '0;
`ifdef FIXED_P_MULT_ARB_SAT_EN
      total++;
      if (overflow !== ((c == 3) ? 4'b0100 : 4'b0000)) begin
        bad++; $display("FAIL overflow_flag c=%0d got=%b", c, overflow);
      end
`endif
    end
    total++;
    if (done !== 4'b0100) begin bad++; $display("FAIL overflow_done got=%b want=0100", done); end
    total++;
    if (slice(out, 2) !== exp_val) begin
      bad++; $display("FAIL overflow_out got=%h want=%h", slice(out, 2), exp_val);
    end
    idle(2);
  endtask

  task automatic test_reset_mid();
    set_ops(0, 32'h0180_0000, 32'h0200_0000);
    go = 4'b0001;
    step();
    go      = '0;
    reset_n = 1'b0;
    step();
    total++;
    if (done !== '0 || out !== '0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_mid_outputs done=%b busy=%b out=%h want all zero", done, busy, out);
    end
    step();
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      total++;
      if (done !== '0) begin bad++; $display("FAIL reset_mid_no_done c=%0d got=%b", c, done); end
    end
    set_ops(0, 32'h0300_0000, 32'h0080_0000);
    go = 4'b0001;
    for (int c = 1; c <= 3; c++) begin
      step();
      if (c == 1) go = '0;
    end
    total++;
    if (done !== 4'b0001) begin bad++; $display("FAIL reset_mid_redo_done got=%b want=0001", done); end
    total++;
    if (slice(out, 0) !== 32'h0180_0000) begin
      bad++; $display("FAIL reset_mid_redo_out got=%h want=01800000", slice(out, 0));
    end
    idle(2);
  endtask

  task automatic test_go_held();
    logic             exp_d;
    logic [WIDTH-1:0] exp_o;
    set_ops(1, 32'h0100_0000, 32'h0100_0000);
    go = 4'b0010;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 1) set_ops(1, 32'h0200_0000, 32'h0200_0000);
      exp_d = (c == 3 || c == 7 || c == 11);
      exp_o = (c < 3) ? 32'h0 : (c < 7) ? 32'h0100_0000 : 32'h0400_0000;
      total++;
      if (done !== {2'b00, exp_d, 1'b0}) begin
        bad++; $display("FAIL go_held_done c=%0d got=%b want=%b", c, done, {2'b00, exp_d, 1'b0});
      end
      total++;
      if (slice(out, 1) !== exp_o) begin
        bad++; $display("FAIL go_held_out c=%0d got=%h want=%h", c, slice(out, 1), exp_o);
      end
      if (c == 11) go = '0;
    end
    idle(5);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL go_held_busy_end got=%b want=0", busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_rotation();
    test_overflow();
    test_reset_mid();
    test_go_held();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
